// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Entries carry a fixed-width PC field so the buffer is independent of XLEN.
package fetch_pkg;

    localparam int ILEN     = 32;
    localparam int PC_INC   = 4;
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [ILEN-1:0]     instr;
        logic                filled;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Ring of fetch entries: alloc reserves a slot on request, fill writes the response, pop retires the head.
// Zero-latency head read; flush empties the ring by collapsing head/fill onto alloc.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_alloc_en,
    input  logic [PC_MAX_W-1:0]        i_alloc_pc,
    input  logic                       i_fill_en,
    input  logic [ILEN-1:0]            i_fill_instr,
    input  logic                       i_pop_en,
    input  logic                       i_flush_en,
    output fetch_entry_t               o_head,
    output logic [ptr_w(DEPTH)-1:0]    o_occ,
    output logic [ptr_w(DEPTH)-1:0]    o_pending,
    output logic                       o_not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_alloc <= '0;
            r_fill  <= '0;
        end else if (i_flush_en) begin
            r_head <= r_alloc;
            r_fill <= r_alloc;
        end else begin
            if (i_alloc_en) r_alloc <= r_alloc + 1'b1;
            if (i_fill_en)  r_fill  <= r_fill + 1'b1;
            if (i_pop_en)   r_head  <= r_head + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (i_alloc_en && !i_flush_en) begin
            r_mem[r_alloc[AW-1:0]].pc     <= i_alloc_pc;
            r_mem[r_alloc[AW-1:0]].filled <= 1'b0;
        end
        if (i_fill_en && !i_flush_en) begin
            r_mem[r_fill[AW-1:0]].instr  <= i_fill_instr;
            r_mem[r_fill[AW-1:0]].filled <= 1'b1;
        end
    end

    assign o_head      = r_mem[r_head[AW-1:0]];
    assign o_occ       = r_alloc - r_head;
    assign o_pending   = r_alloc - r_fill;
    assign o_not_empty = (r_head != r_fill);

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, issues word fetches under credit, buffers responses for decode.
// Rsp-to-decode latency 1 cycle; decode stalls back up into the buffer and throttle requests via credit.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-3:0]   imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [ILEN-1:0]   imem_rsp_data_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [ILEN-1:0]   dec_instr_o,
    output logic [XLEN-1:0]   dec_pc_o,
    output logic [XLEN-1:0]   dec_pc_plus4_o
);

    localparam int            PW     = ptr_w(DEPTH);
    localparam logic [PW:0]   DEPTH_U = (PW+1)'(DEPTH);

    logic [XLEN-1:0]     r_pc;
    logic [PW-1:0]       r_drop_cnt;

    fetch_entry_t        w_head;
    logic [PW-1:0]       w_occ;
    logic [PW-1:0]       w_pending;
    logic                w_not_empty;
    logic [PW:0]         w_used;
    logic                w_req_fire;
    logic                w_fill;
    logic                w_pop;
    logic [PC_MAX_W-1:0] w_alloc_pc;
    logic                w_unused;

    // Credit counts slots already allocated plus stale responses still owed by memory.
    assign w_used           = {1'b0, w_occ} + {1'b0, r_drop_cnt};
    assign imem_req_valid_o = !rst && !redirect_i && (w_used < DEPTH_U);
    assign imem_req_addr_o  = r_pc[XLEN-1:2];
    assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;
    assign w_alloc_pc       = PC_MAX_W'(r_pc);

    assign w_fill      = imem_rsp_valid_i && !redirect_i && (r_drop_cnt == '0);
    assign dec_valid_o = w_not_empty && !redirect_i;
    assign w_pop       = dec_valid_o && dec_ready_i;

    assign dec_instr_o    = w_head.instr;
    assign dec_pc_o       = w_head.pc[XLEN-1:0];
    assign dec_pc_plus4_o = w_head.pc[XLEN-1:0] + XLEN'(PC_INC);

    assign w_unused = ^{redirect_pc_i[1:0], w_head.pc, w_head.filled};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_pc       <= {redirect_pc_i[XLEN-1:2], 2'b00};
            // Everything allocated but not yet filled becomes stale; a response landing now is consumed here.
            r_drop_cnt <= r_drop_cnt + w_pending - PW'(imem_rsp_valid_i);
        end else begin
            if (w_req_fire) r_pc <= r_pc + XLEN'(PC_INC);
            if (imem_rsp_valid_i && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_en   (w_req_fire),
        .i_alloc_pc   (w_alloc_pc),
        .i_fill_en    (w_fill),
        .i_fill_instr (imem_rsp_data_i),
        .i_pop_en     (w_pop),
        .i_flush_en   (redirect_i),
        .o_head       (w_head),
        .o_occ        (w_occ),
        .o_pending    (w_pending),
        .o_not_empty  (w_not_empty)
    );

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with an in-order variable-latency memory model.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int mc     = 0;
    int acc_cnt = 0;

    typedef struct {logic [29:0] addr; int due;} pend_t;
    typedef struct {logic [31:0] pc; logic [31:0] instr; logic [31:0] pc4;} obs_t;
    pend_t pq[$];
    obs_t  obs[$];

    always #5 clk = ~clk;

    fetch_queue_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100),
        .DEPTH    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_instr_o      (dec_instr),
        .dec_pc_o         (dec_pc),
        .dec_pc_plus4_o   (dec_pc4)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A3C_96E1;
    endfunction

    // Memory responder and decode monitor, both sampling mid-cycle.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(negedge clk);
            mc++;
            rsp_valid = 1'b0;
            if (rst) begin
                pq.delete();
                acc_cnt = 0;
            end else begin
                if (pq.size() > 0 && pq[0].due <= mc) begin
                    rsp_valid = 1'b1;
                    rsp_data  = instr_of({pq[0].addr, 2'b00});
                    void'(pq.pop_front());
                end
                if (req_valid && req_ready) begin
                    pq.push_back('{req_addr, mc + lat});
                    acc_cnt++;
                end
                if (dec_valid && dec_ready)
                    obs.push_back('{dec_pc, dec_instr, dec_pc4});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        req_ready = 1'b1; dec_ready = 1'b1; lat = 1;
        step(); step(); step();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        rst = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 30'h40) begin errors++; $display("FAIL first_req_addr: got %h expected 40", req_addr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL first_dec_valid: got %b expected 0", dec_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        for (int k = 0; k < 10; k++) begin
            epc = 32'h100 + 32'(4 * (k - 2));
            checks++; if (dec_valid !== (k >= 2)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, dec_valid, (k >= 2)); end
            checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL stream_req[%0d]: got %b expected 1", k, req_valid); end
            if (k >= 2) begin
                checks++; if (dec_pc !== epc) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, dec_pc, epc); end
                checks++; if (dec_pc4 !== epc + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d]: got %h expected %h", k, dec_pc4, epc + 32'd4); end
                checks++; if (dec_instr !== instr_of(epc)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, dec_instr, instr_of(epc)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int ob;
        logic [31:0] epc;
        lat = 1; req_ready = 1'b1; dec_ready = 1'b0;
        do_reset();
        repeat (10) step();
        checks++; if (acc_cnt !== 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc_cnt); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", req_valid); end
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL bp_dec_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 32'h100) begin errors++; $display("FAIL bp_head_pc: got %h expected 00000100", dec_pc); end
        ob = obs.size();
        dec_ready = 1'b1;
        repeat (14) step();
        checks++; if (obs.size() - ob < 10) begin errors++; $display("FAIL bp_drain_count: got %0d expected >=10", obs.size() - ob); end
        for (int i = 0; i < 10 && ob + i < obs.size(); i++) begin
            epc = 32'h100 + 32'(4 * i);
            checks++; if (obs[ob+i].pc !== epc) begin errors++; $display("FAIL bp_order_pc[%0d]: got %h expected %h", i, obs[ob+i].pc, epc); end
            checks++; if (obs[ob+i].instr !== instr_of(epc)) begin errors++; $display("FAIL bp_order_instr[%0d]: got %h expected %h", i, obs[ob+i].instr, instr_of(epc)); end
        end
    endtask

    task automatic test_redirect_inflight();
        int ob;
        lat = 4; dec_ready = 1'b1; req_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rdi_pre_req: got %b expected 1", req_valid); end
        ob = obs.size();
        redirect = 1'b1; redirect_pc = 32'h0000_2002;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rdi_req_withdrawn: got %b expected 0", req_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdi_dec_blocked: got %b expected 0", dec_valid); end
        step();
        redirect = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rdi_target_req: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 30'h800) begin errors++; $display("FAIL rdi_target_addr: got %h expected 800", req_addr); end
        repeat (10) step();
        checks++; if (obs.size() - ob < 2) begin errors++; $display("FAIL rdi_count: got %0d expected >=2", obs.size() - ob); end
        if (obs.size() - ob >= 2) begin
            checks++; if (obs[ob].pc !== 32'h2000) begin errors++; $display("FAIL rdi_first_pc: got %h expected 00002000", obs[ob].pc); end
            checks++; if (obs[ob].instr !== instr_of(32'h2000)) begin errors++; $display("FAIL rdi_first_instr: got %h expected %h", obs[ob].instr, instr_of(32'h2000)); end
            checks++; if (obs[ob+1].pc !== 32'h2004) begin errors++; $display("FAIL rdi_second_pc: got %h expected 00002004", obs[ob+1].pc); end
        end
    endtask

    task automatic test_redirect_collision();
        int ob;
        lat = 2; dec_ready = 1'b1; req_ready = 1'b1;
        do_reset();
        step(); step(); step(); step();
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL rdc_pre_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 32'h104) begin errors++; $display("FAIL rdc_pre_pc: got %h expected 00000104", dec_pc); end
        ob = obs.size();
        redirect = 1'b1; redirect_pc = 32'h0000_3000;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdc_no_pop: got %b expected 0", dec_valid); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rdc_no_req: got %b expected 0", req_valid); end
        step();
        redirect = 1'b0;
        #1;
        checks++; if (obs.size() !== ob) begin errors++; $display("FAIL rdc_popped: got %0d expected %0d", obs.size(), ob); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdc_empty_after: got %b expected 0", dec_valid); end
        checks++; if (req_addr !== 30'hC00) begin errors++; $display("FAIL rdc_target_addr: got %h expected c00", req_addr); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdc_empty_r6: got %b expected 0", dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rdc_empty_r7: got %b expected 0", dec_valid); end
        step();
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL rdc_target_valid: got %b expected 1", dec_valid); end
        checks++; if (dec_pc !== 32'h3000) begin errors++; $display("FAIL rdc_target_pc: got %h expected 00003000", dec_pc); end
        checks++; if (dec_instr !== instr_of(32'h3000)) begin errors++; $display("FAIL rdc_target_instr: got %h expected %h", dec_instr, instr_of(32'h3000)); end
    endtask

    task automatic test_wrap();
        int ob;
        logic [31:0] exp_pc  [3];
        logic [31:0] exp_pc4 [3];
        exp_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        exp_pc4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        lat = 1; dec_ready = 1'b1; req_ready = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wrap_req_withdrawn: got %b expected 0", req_valid); end
        step();
        redirect = 1'b0;
        ob = obs.size();
        #1;
        checks++; if (req_addr !== 30'h3FFF_FFFE) begin errors++; $display("FAIL wrap_req_addr: got %h expected 3ffffffe", req_addr); end
        repeat (8) step();
        checks++; if (obs.size() - ob < 3) begin errors++; $display("FAIL wrap_count: got %0d expected >=3", obs.size() - ob); end
        for (int i = 0; i < 3 && ob + i < obs.size(); i++) begin
            checks++; if (obs[ob+i].pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, obs[ob+i].pc, exp_pc[i]); end
            checks++; if (obs[ob+i].pc4 !== exp_pc4[i]) begin errors++; $display("FAIL wrap_pc4[%0d]: got %h expected %h", i, obs[ob+i].pc4, exp_pc4[i]); end
            checks++; if (obs[ob+i].instr !== instr_of(exp_pc[i])) begin errors++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, obs[ob+i].instr, instr_of(exp_pc[i])); end
        end
    endtask

    task automatic test_async_reset();
        int ob;
        lat = 1; dec_ready = 1'b0; req_ready = 1'b1;
        do_reset();
        step(); step(); step();
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", dec_valid); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL ar_req_valid: got %b expected 0", req_valid); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL ar_dec_valid: got %b expected 0", dec_valid); end
        step();
        dec_ready = 1'b1;
        rst = 1'b0;
        ob = obs.size();
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL ar_restart_req: got %b expected 1", req_valid); end
        checks++; if (req_addr !== 30'h40) begin errors++; $display("FAIL ar_restart_addr: got %h expected 40", req_addr); end
        repeat (6) step();
        checks++; if (obs.size() - ob < 1) begin errors++; $display("FAIL ar_count: got %0d expected >=1", obs.size() - ob); end
        if (obs.size() - ob >= 1) begin
            checks++; if (obs[ob].pc !== 32'h100) begin errors++; $display("FAIL ar_first_pc: got %h expected 00000100", obs[ob].pc); end
            checks++; if (obs[ob].instr !== instr_of(32'h100)) begin errors++; $display("FAIL ar_first_instr: got %h expected %h", obs[ob].instr, instr_of(32'h100)); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch stage with a decoupled instruction-memory request/response interface and a DEPTH-entry fetch buffer feeding decode over a valid/ready handshake. Owns the fetch PC and issues sequential word fetches while credit is available. Absorbs variable memory latency and decode stalls, and takes branch/jump redirects from decode. Redirects flush buffered instructions and discard stale in-flight responses. Sits between the PC/instruction memory and the decode stage, replacing the fixed single-register IF/ID boundary.

## Interface
- XLEN, 32: address/PC width; instructions are always 32 bits.
- RESET_PC, 0: fetch PC after reset; must be word-aligned.
- DEPTH, 4: fetch buffer entries and maximum in-flight plus buffered fetches; power of 2, ≥ 2.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_i  in  1  decode redirect (branch taken or jump)
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN-2  word address = fetch PC[XLEN-1:2]
- imem_rsp_valid_i  in  1  response valid; in order, one per accepted request, no backpressure
- imem_rsp_data_i  in  32  instruction word
- dec_valid_o  out  1  buffer head valid to decode
- dec_ready_i  in  1  decode accepts head
- dec_instr_o  out  32  head instruction
- dec_pc_o  out  XLEN  head PC
- dec_pc_plus4_o  out  XLEN  head PC + 4, modulo 2^XLEN

## Operation
- **State:**
  - pc_q: fetch PC.
  - Ring of DEPTH entries {pc, instr, filled}, with pointers head/alloc/fill of log2(DEPTH)+1 bits.
  - drop_cnt: 0..DEPTH stale responses still to discard.
- **Credit:** `used = (alloc − head) + drop_cnt`, computed from registered values only; a same-cycle pop adds no credit.
- **Request:** imem_req_valid_o = !rst && !redirect_i && used < DEPTH.
  - On accept: write pc_q into the entry at alloc, clear filled, alloc++, pc_q += 4 (wraps at 2^XLEN).
  - The request is held stable until accepted, except when withdrawn by redirect_i.
- **Response:**
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: write instr into the entry at fill, set filled, fill++.
- **Decode output:** dec_valid_o = (head != fill) && !redirect_i. Outputs come straight from the head entry. A dec_valid_o && dec_ready_i handshake pops the entry (head++).
- **Redirect** (priority over everything else in the same cycle):
  - pc_q ← {redirect_pc_i[XLEN-1:2], 2'b00}.
  - head, fill, alloc all ← the current alloc value, so the buffer is empty.
  - drop_cnt ← drop_cnt + (alloc − fill) − (1 if a response arrives this cycle).
  - A response arriving in the redirect cycle is discarded.
  - No pop and no request occur that cycle.
  - Back-to-back redirects: each one recomputes drop_cnt from the current state; the last one wins pc_q.
- **Reset** (any time, including mid-flight):
  - pc_q = RESET_PC; all pointers = 0; drop_cnt = 0.
  - imem_req_valid_o = 0, dec_valid_o = 0.
  - Memory must also be reset, so pre-reset responses never arrive.
- **Full / empty:**
  - used == DEPTH: no request.
  - head == fill: dec_valid_o = 0, and data outputs are don't-care (they hold the last entry).

## Timing
- The first request is presented in the first cycle after rst deasserts, at address RESET_PC>>2.
- Response registered in cycle N → dec_valid_o in cycle N+1; there is no combinational path from rsp to dec.
- Memory with 1-cycle response latency: first instruction reaches decode 2 cycles after request acceptance.
- Sustained throughput is 1 instruction/cycle when DEPTH ≥ 4, memory is always ready with 1-cycle latency, and decode is always ready.
- Combinational paths:
  - redirect_i → imem_req_valid_o and dec_valid_o.
  - Nothing from dec_ready_i to imem_req_valid_o.
- Redirect in cycle R → request for the target presented in R+1.

## Structure
- Shared package fetch_pkg:
  - fetch_entry_t {pc, instr, filled}.
  - Constant ILEN = 32.
  - Constant PC_INC = 4.
- One sub-module, fetch_buffer: ring storage with alloc/fill/pop/flush ports and occupancy outputs.
- The top level holds pc_q, drop_cnt, credit and redirect logic.

## Test plan
- **Reset stream:** RESET_PC=0x100, memory 1-cycle latency, always ready; decode always ready → decode sees pc 0x100, 0x104, 0x108 … one per cycle, pc_plus4 = pc+4, first dec_valid_o 2 cycles after the first accept.
- **Backpressure:** hold dec_ready_i=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid_o=0; after release, in-order PCs with none lost or duplicated.
- **Redirect with 3 in flight:** memory latency 4, redirect to 0x2002 → next request address 0x800 (PC 0x2000); 3 stale responses dropped; first dec_pc_o = 0x2000.
- **Redirect coinciding with a response and a decode handshake:** no pop that cycle, response discarded, drop_cnt = in-flight − 1, buffer empty the next cycle.
- **PC wrap:** RESET_PC=0xFFFFFFF8 → PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; pc_plus4 of 0xFFFFFFFC is 0x00000000.
- **Async reset mid-stream:** assert rst between clock edges with the buffer half full → all outputs are reset values immediately; fetch restarts at RESET_PC.
